led_pattern_engine: RTL and testbench

Parametrised, single-clock LED pattern sequencer driving a WIDTH-bit LED bank through eight selectable animations. Its step rate is set by a prescaler plus a power-of-two speed selector. Pattern changes are applied only on frame boundaries, and a pause with single-step mode is provided for bring-up and demos. It sits between the board's switch/button synchronisers and the LED pads.

---
 rtl/led_pattern_engine_if.sv | 26 ++
 rtl/led_pattern_engine.sv | 139 +++++++++++++
 tb/tb_led_pattern_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_engine_if.sv
// Control and LED-drive bundle between the switch/button synchronisers and the
// pattern engine.
interface led_pattern_engine_if #(
   parameter int WIDTH   = 8,
   parameter int SPEED_W = 2
);
   // frame_tick is a valid strobe with no ready: led_out holds a new frame exactly
   // in the cycles frame_tick is high, and the LED side can never stall the engine.
   logic               ena;
   logic [2:0]         pat_sel;
   logic [SPEED_W-1:0] speed_sel;
   logic               pause;
   logic               step;
   logic [WIDTH-1:0]   led_out;
   logic               frame_tick;

   modport master (
      output ena, pat_sel, speed_sel, pause, step,
      input  led_out, frame_tick
   );

   modport slave (
      input  ena, pat_sel, speed_sel, pause, step,
      output led_out, frame_tick
   );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern sequencer: eight animations stepped by a prescaler plus a
// power-of-two divider, with frame-boundary pattern switching and paused single-step.
module led_pattern_engine #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1,
   parameter int SPEED_W  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   led_pattern_engine_if.slave bus,
   output logic [2:0]          dbg_active
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DIV_W = (1 << SPEED_W) - 1;
   localparam int DT_W  = DIV_W + 1;
   localparam int PH_W  = $clog2(2 * WIDTH - 2);
   localparam int HALF  = WIDTH / 2;

   typedef enum logic [2:0] {
      PAT_KNIGHT, PAT_PAIR, PAT_EXPAND, PAT_BLINK,
      PAT_ALT, PAT_MARQUEE, PAT_SPARKLE, PAT_OFF
   } pat_e;

   logic [PRE_W-1:0] pre_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic             step_q1, step_q2;
   pat_e             pat_q, active;
   logic [PH_W-1:0]  phase;
   logic [15:0]      lfsr;
   logic [WIDTH-1:0] led_q;
   logic             tick_q;

   logic [DT_W-1:0]  div_thr;
   logic             base_tick, timed_step, paused_step, fire, do_switch;
   pat_e             active_next;
   logic [PH_W-1:0]  cur_ph, nxt_ph;
   logic [15:0]      cur_lfsr, nxt_lfsr;
   logic [WIDTH-1:0] frame;
   int               ph_i, pos, lvl, last_ph;

   assign div_thr     = (DT_W'(1) << bus.speed_sel) - DT_W'(1);
   assign base_tick   = bus.ena && !bus.pause && (pre_cnt == PRE_W'(PRESCALE - 1));
   // ">=" lets a mid-count speed decrease fire on the very next base tick
   assign timed_step  = base_tick && ({1'b0, div_cnt} >= div_thr);
   assign paused_step = bus.ena && bus.pause && step_q1 && !step_q2;
   assign fire        = timed_step || paused_step;
   assign do_switch   = fire && (pat_q != active);

   always_comb begin
      active_next = active;
      cur_ph      = phase;
      cur_lfsr    = lfsr;
      if (do_switch) begin
         active_next = pat_q;
         cur_ph      = '0;
         cur_lfsr    = 16'hACE1;
      end
      ph_i    = int'(cur_ph);
      pos     = 0;
      lvl     = 0;
      last_ph = 0;
      frame   = '0;
      case (active_next)
         PAT_KNIGHT: begin
            last_ph = 2 * WIDTH - 3;
            pos     = (ph_i < WIDTH) ? ph_i : 2 * WIDTH - 2 - ph_i;
            frame   = WIDTH'(1) << pos;
         end
         PAT_PAIR: begin
            last_ph = 2 * WIDTH - 5;
            pos     = (ph_i < WIDTH - 1) ? ph_i : 2 * WIDTH - 4 - ph_i;
            frame   = WIDTH'(3) << pos;
         end
         PAT_EXPAND: begin
            last_ph = WIDTH - 1;
            lvl     = (ph_i < HALF) ? ph_i + 1 : WIDTH - 1 - ph_i;
            for (int i = 0; i < WIDTH; i++)
               frame[i] = (i >= HALF - lvl) && (i < HALF + lvl);
         end
         PAT_BLINK: begin
            last_ph = 1;
            frame   = (ph_i == 0) ? '1 : '0;
         end
         PAT_ALT: begin
            last_ph = 1;
            for (int i = 0; i < WIDTH; i++)
               frame[i] = ((i % 2) == 1) ^ (ph_i != 0);
         end
         PAT_MARQUEE: begin
            last_ph = WIDTH - 1;
            frame   = (WIDTH'(7) << ph_i) | (WIDTH'(7) >> (WIDTH - ph_i));
         end
         PAT_SPARKLE: frame = cur_lfsr[WIDTH-1:0];
         default:     frame = '0;
      endcase
      nxt_ph   = (ph_i == last_ph) ? '0 : cur_ph + PH_W'(1);
      nxt_lfsr = cur_lfsr;
      if (active_next == PAT_SPARKLE)
         nxt_lfsr = {cur_lfsr[14:0], cur_lfsr[15] ^ cur_lfsr[13] ^ cur_lfsr[12] ^ cur_lfsr[10]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         div_cnt <= '0;
         step_q1 <= 1'b0;
         step_q2 <= 1'b0;
         pat_q   <= PAT_KNIGHT;
         active  <= PAT_KNIGHT;
         phase   <= '0;
         lfsr    <= 16'hACE1;
         led_q   <= '0;
         tick_q  <= 1'b0;
      end else if (bus.ena) begin
         pat_q   <= pat_e'(bus.pat_sel);
         step_q1 <= bus.step;
         step_q2 <= step_q1;
         if (!bus.pause)
            pre_cnt <= (pre_cnt == PRE_W'(PRESCALE - 1)) ? '0 : pre_cnt + PRE_W'(1);
         if (base_tick)
            div_cnt <= timed_step ? '0 : div_cnt + DIV_W'(1);
         tick_q <= fire;
         if (fire) begin
            active <= active_next;
            phase  <= nxt_ph;
            lfsr   <= nxt_lfsr;
            led_q  <= frame;
         end
      end else begin
         tick_q <= 1'b0;
      end
   end

   assign bus.led_out    = led_q;
   assign bus.frame_tick = tick_q;
   assign dbg_active     = active;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Random and directed stimulus for led_pattern_engine, checked by a scoreboard fed
// from a frame-table reference model of the animations and step timing.
module tb_led_pattern_engine;

   localparam int W  = 8;
   localparam int P  = 2;
   localparam int SW = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] dbg_active;

   led_pattern_engine_if #(.WIDTH(W), .SPEED_W(SW)) bus ();

   led_pattern_engine #(.WIDTH(W), .PRESCALE(P), .SPEED_W(SW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .dbg_active (dbg_active)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Frame tables built straight from the animation descriptions
   logic [W-1:0] tbl[8][32];
   int           tlen[8];

   task automatic build_tables();
      int n;
      logic [W-1:0] v;
      int lv;
      n = 0;
      for (int i = 0; i < W; i++) begin tbl[0][n] = W'(1) << i; n++; end
      for (int i = W - 2; i >= 1; i--) begin tbl[0][n] = W'(1) << i; n++; end
      tlen[0] = n;
      n = 0;
      for (int i = 0; i <= W - 2; i++) begin tbl[1][n] = W'(3) << i; n++; end
      for (int i = W - 3; i >= 1; i--) begin tbl[1][n] = W'(3) << i; n++; end
      tlen[1] = n;
      for (int ph = 0; ph < W; ph++) begin
         lv = (ph < W / 2) ? ph + 1 : W - 1 - ph;
         v  = '0;
         for (int b = W / 2 - lv; b < W / 2 + lv; b++) v[b] = 1'b1;
         tbl[2][ph] = v;
      end
      tlen[2] = W;
      tbl[3][0] = '1; tbl[3][1] = '0; tlen[3] = 2;
      v = '0;
      for (int b = 1; b < W; b += 2) v[b] = 1'b1;
      tbl[4][0] = v; tbl[4][1] = ~v; tlen[4] = 2;
      v = W'(7);
      for (int i = 0; i < W; i++) begin
         tbl[5][i] = v;
         v = {v[W-2:0], v[W-1]};
      end
      tlen[5] = W;
      tbl[6][0] = '0; tlen[6] = 1;
      tbl[7][0] = '0; tlen[7] = 1;
   endtask

   // Reference model: timing rules plus which frame each step shows
   int          cyc = 0;
   int          m_tot = 0, m_ticks = 0, m_idx = 0;
   int          m_pat_q = 0, m_active = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic        m_hist[2] = '{1'b0, 1'b0};
   logic        m_fire;
   logic [W-1:0] m_frame;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tot = 0; m_ticks = 0; m_idx = 0;
         m_pat_q = 0; m_active = 0;
         m_lfsr = 16'hACE1;
         m_hist[0] = 1'b0; m_hist[1] = 1'b0;
         exp_q.delete();
         exp_cyc_q.delete();
      end else begin
         cyc++;
         m_fire = 1'b0;
         if (bus.ena) begin
            if (!bus.pause) begin
               m_tot++;
               if (m_tot % P == 0) begin
                  m_ticks++;
                  if (m_ticks >= (1 << bus.speed_sel)) begin
                     m_fire  = 1'b1;
                     m_ticks = 0;
                  end
               end
            end else if (m_hist[0] && !m_hist[1]) begin
               m_fire = 1'b1;
            end
            if (m_fire) begin
               if (m_pat_q != m_active) begin
                  m_active = m_pat_q;
                  m_idx    = 0;
                  m_lfsr   = 16'hACE1;
               end
               if (m_active == 6) begin
                  m_frame = m_lfsr[W-1:0];
                  m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
               end else begin
                  m_frame = tbl[m_active][m_idx % tlen[m_active]];
               end
               m_idx++;
               exp_q.push_back(m_frame);
               exp_cyc_q.push_back(cyc);
            end
            m_hist[1] = m_hist[0];
            m_hist[0] = bus.step;
            m_pat_q   = int'(bus.pat_sel);
         end
      end
   end

   // Monitor: pops an expected frame whenever the engine presents one
   logic [W-1:0] shown = '0;
   logic [W-1:0] el;
   int           ec;

   always @(negedge clk) begin
      if (!rst_n) begin
         shown = '0;
      end else begin
         if (bus.frame_tick) begin
            chk("tick_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               el = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               chk("frame_led", 32'(bus.led_out), 32'(el));
               chk("frame_cycle", cyc, ec);
               shown = el;
            end
         end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            chk("tick_on_time", 32'(bus.frame_tick), 1);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
         chk("led_hold", 32'(bus.led_out), 32'(shown));
      end
   end

   task automatic drive(input int pat, input int spd, input bit en, input bit pa, input int n);
      bus.pat_sel   = 3'(pat);
      bus.speed_sel = SW'(spd);
      bus.ena       = en;
      bus.pause     = pa;
      repeat (n) @(negedge clk);
   endtask

   task automatic step_pulse(input int hi, input int lo);
      bus.step = 1'b1;
      repeat (hi) @(negedge clk);
      bus.step = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   initial begin
      build_tables();
      bus.ena = 1'b1; bus.pat_sel = 3'd0; bus.speed_sel = '0;
      bus.pause = 1'b0; bus.step = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_led", 32'(bus.led_out), 0);
      chk("reset_tick", 32'(bus.frame_tick), 0);
      chk("reset_active", 32'(dbg_active), 0);
      rst_n = 1'b1;

      drive(0, 0, 1, 0, 34);   // knight bounce
      drive(3, 2, 1, 0, 20);   // blink, slow
      drive(3, 0, 1, 0, 6);    // speed drop mid-count
      drive(1, 0, 1, 0, 10);   // walking pair
      drive(5, 0, 1, 0, 20);   // marquee
      drive(2, 1, 1, 0, 40);   // expand/contract
      drive(6, 0, 1, 0, 6);    // sparkle
      drive(6, 0, 1, 1, 100);  // paused hold
      repeat (3) step_pulse(1, 3);
      step_pulse(10, 4);
      drive(4, 0, 0, 0, 10);   // disabled freeze
      drive(4, 0, 1, 0, 8);

      for (int s = 0; s < 60; s++) begin
         bus.pat_sel   = 3'($urandom_range(0, 7));
         bus.speed_sel = SW'($urandom_range(0, 3));
         bus.pause     = ($urandom_range(0, 3) == 0);
         bus.ena       = ($urandom_range(0, 7) != 0);
         for (int c = 0, n = $urandom_range(1, 14); c < n; c++) begin
            bus.step = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end

      bus.step = 1'b0;
      drive(5, 0, 1, 0, 9);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_led", 32'(bus.led_out), 0);
      chk("async_rst_tick", 32'(bus.frame_tick), 0);
      @(negedge clk);
      bus.pat_sel = 3'd4;
      @(negedge clk);
      rst_n = 1'b1;
      drive(4, 0, 1, 0, 12);

      drive(4, 0, 1, 1, 5);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
